// File: rtl/mic_window_scheduler.sv
// Microphone sampling scheduler: ADC conversion clock, 12-bit sample capture, windowed peak tracking
// and valid/ready publication of peak + 0..9 level. Optional build macro: MIC_PEAK_DECAY_EN.
module mic_window_scheduler #(
  parameter int SAMPLE_DIV     = 2500,
  parameter int WINDOW_SAMPLES = 4000
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        en,
  input  logic [11:0] sample_in,
  output logic        cs,
  output logic        samp_tick,
  output logic        busy,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [11:0] peak_out,
  output logic [3:0]  level_out,
  output logic        overrun,
  output logic [1:0]  state_dbg
);

  // Output handshake: a result is transferred in any cycle where out_valid & out_ready are both
  // high; out_valid then drops the next cycle unless a new result is published in that same cycle.

  localparam int TW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int SW = $clog2(WINDOW_SAMPLES + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARM     = 2'd1,
    S_ACCUM   = 2'd2,
    S_PUBLISH = 2'd3
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [TW-1:0]   tick_q;
  logic [SW-1:0]   sample_cnt_q;
  logic [11:0]     peak_q;
  logic            tick_zero;
  logic            tick_last;
  logic            window_done;
  logic [11:0]     peak_max;
  logic [11:0]     peak_reseed;
  logic [14:0]     lvl_diff;
  logic [14:0]     lvl_prod;
  logic [14:0]     lvl_sum;
  logic [3:0]      level_calc;

  assign tick_zero   = (tick_q == '0);
  assign tick_last   = (tick_q == TW'(SAMPLE_DIV - 1));
  assign busy        = (state_q != S_IDLE);
  assign cs          = busy && (tick_q < TW'(SAMPLE_DIV / 2));
  assign samp_tick   = (state_q == S_ACCUM) && tick_zero;
  assign window_done = samp_tick && (sample_cnt_q == SW'(WINDOW_SAMPLES - 1));
  assign peak_max    = (sample_in > peak_q) ? sample_in : peak_q;
  assign state_dbg   = state_q;

  // Level 1..9 spreads the upper half of the ADC range over 9 steps; midscale and below is silence.
  always_comb begin
    lvl_diff   = {3'b000, peak_q - 12'd2049};
    lvl_prod   = lvl_diff * 15'd9;
    lvl_sum    = 15'd1 + (lvl_prod >> 11);
    level_calc = (peak_q > 12'd2048) ? lvl_sum[3:0] : 4'd0;
  end

`ifdef MIC_PEAK_DECAY_EN
  // Halve the excursion above midscale so the displayed level falls off gradually.
  assign peak_reseed = (peak_q > 12'd2048) ? (peak_q - ((peak_q - 12'd2048) >> 1)) : 12'd0;
`else
  assign peak_reseed = 12'd0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (en) state_d = S_ARM;
      S_ARM:     if (tick_zero) state_d = S_ACCUM;
      S_ACCUM:   if (window_done) state_d = S_PUBLISH;
      S_PUBLISH: state_d = S_ACCUM;
      default:   state_d = S_IDLE;
    endcase
    if (!en) state_d = S_IDLE;
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // The tick counter free-runs through ARM, ACCUM and PUBLISH so sample spacing never slips.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      tick_q <= '0;
    end else if (state_q == S_IDLE || !en) begin
      tick_q <= '0;
    end else if (tick_last) begin
      tick_q <= '0;
    end else begin
      tick_q <= tick_q + TW'(1);
    end
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      peak_q       <= '0;
      sample_cnt_q <= '0;
    end else if (state_q == S_IDLE || !en) begin
      peak_q       <= '0;
      sample_cnt_q <= '0;
    end else if (state_q == S_PUBLISH) begin
      peak_q       <= peak_reseed;
      sample_cnt_q <= '0;
    end else if (samp_tick) begin
      peak_q       <= peak_max;
      sample_cnt_q <= sample_cnt_q + SW'(1);
    end
  end

  // Result registers are independent of en so a pending result can still be accepted while idle.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      out_valid <= 1'b0;
      peak_out  <= '0;
      level_out <= '0;
      overrun   <= 1'b0;
    end else if (state_q == S_PUBLISH) begin
      out_valid <= 1'b1;
      peak_out  <= peak_q;
      level_out <= level_calc;
      if (out_valid && !out_ready) overrun <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mic_window_scheduler.sv
// Directed bench for mic_window_scheduler: scoreboard of published {peak, level} pairs popped on
// each accepted transfer, plus sample-spacing and control/status checks.
module tb_mic_window_scheduler;

  localparam int DIV = 10;
  localparam int WIN = 4;

  logic        CLOCK = 1'b0;
  logic        RESET = 1'b1;
  logic        en = 1'b0;
  logic        out_ready = 1'b1;
  logic [11:0] sample_in = 12'd0;
  logic        cs;
  logic        samp_tick;
  logic        busy;
  logic        out_valid;
  logic [11:0] peak_out;
  logic [3:0]  level_out;
  logic        overrun;
  logic [1:0]  state_dbg;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [15:0] exp_q[$];

  mic_window_scheduler #(.SAMPLE_DIV(DIV), .WINDOW_SAMPLES(WIN)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .en(en), .sample_in(sample_in), .cs(cs),
    .samp_tick(samp_tick), .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .peak_out(peak_out), .level_out(level_out), .overrun(overrun), .state_dbg(state_dbg)
  );

  // clock / cycle counter
  always #5 CLOCK = ~CLOCK;
  initial forever begin
    @(posedge CLOCK);
    cyc = cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask

  // scoreboard monitor: every accepted transfer must match the head of the expected queue
  initial forever begin
    @(negedge CLOCK);
    if (!RESET && out_valid === 1'b1 && out_ready === 1'b1) begin
      checks = checks + 1;
      if (exp_q.size() == 0) begin
        failures = failures + 1;
        $display("FAIL publish_unexpected act=%0d/%0d exp=none", peak_out, level_out);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if ({peak_out, level_out} !== e) begin
          failures = failures + 1;
          $display("FAIL publish act=%0d/%0d exp=%0d/%0d", peak_out, level_out, e[15:4], e[3:0]);
        end
      end
    end
  end

  // sample spacing monitor: consecutive samp_tick pulses within a run must be DIV cycles apart
  initial begin
    int last_tick;
    last_tick = -1;
    forever begin
      @(negedge CLOCK);
      if (RESET || busy !== 1'b1) begin
        last_tick = -1;
      end else if (samp_tick === 1'b1) begin
        if (last_tick >= 0) check("tick_spacing", cyc - last_tick, DIV);
        last_tick = cyc;
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge CLOCK);
    #1;
  endtask

  // Present v and return just after the edge that captures it.
  task automatic feed(input logic [11:0] v);
    int n;
    sample_in = v;
    n = 0;
    while (samp_tick !== 1'b1 && n < 100) begin
      step();
      n = n + 1;
    end
    if (n >= 100) begin
      checks = checks + 1;
      failures = failures + 1;
      $display("FAIL feed_timeout act=%0d exp=<100", n);
    end
    step();
  endtask

  task automatic feed4(input logic [11:0] v);
    for (int i = 0; i < WIN; i++) feed(v);
  endtask

  task automatic restart();
    en = 1'b0;
    step();
    check("restart_busy_low", busy, 0);
    en = 1'b1;
  endtask

  initial begin
    // reset state
    step();
    step();
    check("rst_cs", cs, 0);
    check("rst_samp_tick", samp_tick, 0);
    check("rst_busy", busy, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_peak_out", peak_out, 0);
    check("rst_level_out", level_out, 0);
    check("rst_overrun", overrun, 0);
    check("rst_state", state_dbg, 0);
    RESET = 1'b0;
    step();

    // basic window: peak 3000 -> level 5
    en = 1'b1;
    step();
    check("busy_after_en", busy, 1);
    exp_q.push_back({12'd3000, 4'd5});
    feed(12'd2000);
    feed(12'd3000);
    feed(12'd2500);
    feed(12'd2100);
    check("publish_state", state_dbg, 3);
    step();
    check("t1_valid", out_valid, 1);
    check("t1_peak", peak_out, 3000);
    check("t1_level", level_out, 5);
    step();
    check("t1_valid_cleared", out_valid, 0);

    // full scale then midscale
    exp_q.push_back({12'd4095, 4'd9});
    feed4(12'd4095);
`ifdef MIC_PEAK_DECAY_EN
    exp_q.push_back({12'd3072, 4'd5});
`else
    exp_q.push_back({12'd2048, 4'd0});
`endif
    feed4(12'd2048);
    step();
    step();

    // accept in the exact PUBLISH cycle
    out_ready = 1'b0;
    restart();
    exp_q.push_back({12'd2600, 4'd3});
    feed4(12'd2600);
    step();
    check("t4_valid_pending", out_valid, 1);
    check("t4_overrun_pre", overrun, 0);
    exp_q.push_back({12'd3900, 4'd9});
    feed4(12'd3900);
    check("t4_publish_state", state_dbg, 3);
    out_ready = 1'b1;
    step();
    check("t4_valid_kept", out_valid, 1);
    check("t4_new_peak", peak_out, 3900);
    check("t4_overrun", overrun, 0);
    step();
    check("t4_valid_cleared", out_valid, 0);

    // overwrite without acceptance
    out_ready = 1'b0;
    restart();
    feed4(12'd2200);
    step();
    check("t3_first_peak", peak_out, 2200);
    check("t3_overrun_pre", overrun, 0);
    exp_q.push_back({12'd3500, 4'd7});
    feed4(12'd3500);
    step();
    check("t3_valid", out_valid, 1);
    check("t3_peak", peak_out, 3500);
    check("t3_level", level_out, 7);
    check("t3_overrun", overrun, 1);
    out_ready = 1'b1;
    step();
    check("t3_valid_cleared", out_valid, 0);
    check("t3_overrun_sticky", overrun, 1);

    // en dropped mid-window
    restart();
    feed(12'd3800);
    feed(12'd3700);
    en = 1'b0;
    step();
    check("t5_busy_low", busy, 0);
    step();
    en = 1'b1;
    exp_q.push_back({12'd2300, 4'd2});
    feed(12'd2300);
    feed(12'd2100);
    feed(12'd2200);
    feed(12'd2250);
    step();
    step();

    // asynchronous reset mid-window with a pending result
    out_ready = 1'b0;
    feed4(12'd2900);
    step();
    check("t6_valid_pending", out_valid, 1);
    feed(12'd3000);
    feed(12'd3000);
    RESET = 1'b1;
    #2;
    check("t6_rst_valid", out_valid, 0);
    check("t6_rst_peak", peak_out, 0);
    check("t6_rst_level", level_out, 0);
    check("t6_rst_overrun", overrun, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_cs", cs, 0);
    check("t6_rst_state", state_dbg, 0);
    step();
    RESET = 1'b0;
    out_ready = 1'b1;
    exp_q.push_back({12'd3300, 4'd6});
    feed(12'd3300);
    feed(12'd3000);
    feed(12'd3100);
    feed(12'd3200);

    // drain
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
    check("queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mic_window_scheduler.md
# mic_window_scheduler

- Sequences the microphone sampling datapath: generates the ADC conversion clock, captures 12-bit samples and tracks the peak over fixed windows.
- At each window end, publishes the peak and a 0–9 volume level to a downstream consumer (LED/7-seg display logic) over a valid/ready handshake.
- Sits between the Audio_Input serial ADC front end and the display update logic, and replaces free-running divider/peak logic with one controlled FSM.

## Interface
- SAMPLE_DIV, 2500: CLOCK cycles per sample period (100 MHz / 2500 = 40 kHz ticks); must be even and ≥ 4.
- WINDOW_SAMPLES, 4000: samples per peak window; ≥ 1.
- CLOCK  in  1  system clock, 100 MHz.
- RESET  in  1  asynchronous, active-high reset.
- en  in  1  run enable; low forces IDLE.
- sample_in  in  12  latest ADC sample (unsigned, midscale 2048).
- cs  out  1  ADC conversion clock, drives Audio_Input cs.
- samp_tick  out  1  one-cycle pulse on each sample capture.
- busy  out  1  high whenever state ≠ IDLE.
- out_valid  out  1  published result pending.
- out_ready  in  1  consumer accepts result.
- peak_out  out  12  published window peak.
- level_out  out  4  published volume level 0–9.
- overrun  out  1  sticky: a result was overwritten before acceptance.

## Operation
- FSM states: IDLE, ARM, ACCUM, PUBLISH.
- IDLE: tick counter held at 0, cs=0, peak=0, sample count=0. en=1 → ARM.
- ARM: tick counter runs 0..SAMPLE_DIV-1, wrapping; cs = 1 while count < SAMPLE_DIV/2. Enters ACCUM on the first count==0 after entry, discarding that first conversion.
- ACCUM: on each count==0 cycle, samp_tick=1, sample_in is captured, peak ← max(peak, sample_in), and the sample counter increments. When the capture is sample WINDOW_SAMPLES, the next state is PUBLISH.
- PUBLISH (one cycle): registers peak_out ← peak and level_out ← f(peak), sets out_valid=1, then reseeds the window (see Configuration) with sample count=0 and returns to ACCUM. The tick counter keeps running through PUBLISH.
- Level function f(p):
  - p ≤ 2048 → 0.
  - Otherwise 1 + (((p-2049)×9) >> 11), computed on 15 bits; result range 1..9.
- Handshake:
  - out_valid stays high until a cycle with out_valid & out_ready, then clears the next cycle.
  - peak_out and level_out are stable while out_valid=1, except on overwrite.
- Overwrite:
  - PUBLISH with out_valid=1 and out_ready=0 sets overrun=1, replaces the data and keeps out_valid=1.
  - PUBLISH in the same cycle as an accept loads the new data and keeps out_valid=1; overrun is not set.
  - overrun clears only on RESET.
- en deasserted in any state: next state is IDLE, and the partial window is discarded (peak=0, count=0). out_valid, peak_out, level_out and overrun retain their values and the handshake still completes.
- en reasserted: restarts from ARM with a fresh window.

## Timing
- Reset values: cs=0, samp_tick=0, busy=0, out_valid=0, peak_out=0, level_out=0, overrun=0, state=IDLE. RESET takes effect immediately, including mid-window.
- en=1 at cycle 0 → busy=1 at cycle 1.
- The first samp_tick arrives SAMPLE_DIV cycles after ARM's first count==0.
- Final capture at cycle T → PUBLISH at T+1 → out_valid/peak_out/level_out visible at T+2.
- Successive samp_tick pulses are exactly SAMPLE_DIV cycles apart, including across PUBLISH.
- Window period = WINDOW_SAMPLES × SAMPLE_DIV cycles.
- Accept: out_valid & out_ready at cycle A → out_valid=0 at A+1, unless PUBLISH occurs at A.

## Configuration
- MIC_PEAK_DECAY_EN defined: at PUBLISH the next window's peak is seeded with p − ((p − 2048) >> 1) if p > 2048, else 0. The level therefore decays toward silence over successive windows instead of dropping instantly.
- Undefined: the peak is reseeded to 0 at every PUBLISH.
- The macro affects only the reseed value; the IDLE and en-low clear is always 0.

## Test plan
- Params SAMPLE_DIV=10, WINDOW_SAMPLES=4; en=1; samples 2000, 3000, 2500, 2100; out_ready=1 → one out_valid pulse with peak_out=3000, level_out=5; samp_tick spacing exactly 10 cycles.
- Samples all 4095, then all 2048 → first result level 9; second result level 0 without MIC_PEAK_DECAY_EN. With the macro, second result peak 3072 and level 5.
- out_ready held 0 across two windows → out_valid stays 1, second peak replaces the first, overrun=1; raising out_ready clears out_valid next cycle while overrun stays 1.
- out_ready pulsed in the exact PUBLISH cycle → new data loaded, out_valid stays 1, overrun stays 0.
- en dropped after 2 of 4 samples, then restored → no publish from the partial window; the next result reflects only post-restart samples; busy goes low for ≥ 1 cycle.
- RESET asserted mid-window with out_valid=1 → all outputs return to reset values asynchronously; operation resumes from IDLE after release.
